// File: rtl/pwm_carrier_compare_pkg.sv
// rtl/pwm_carrier_compare_pkg.sv - shared types and defaults for the PWM carrier/compare block
// Purpose: carrier mode, run enable and counter direction types, default counter width.
// Ports: none (package).
package pwm_carrier_compare_pkg;

   localparam int CARCOUNT_WIDTH = 16;

   typedef enum logic {CAR_SAW, CAR_TRI} _car_mode;
   typedef enum logic {PWM_OFF, PWM_ON} _pwm_onoff;
   typedef enum logic {DIR_UP, DIR_DOWN} _car_dir;

endpackage

// File: rtl/pwm_carrier_compare_carrier_counter.sv
// rtl/pwm_carrier_compare_carrier_counter.sv - sawtooth/triangle carrier counter with zero/peak flags
// Purpose: free-running carrier with an UP/DOWN direction state; exposes the next count so the
//          parent can register pwm against the same value that becomes the carrier output.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   run            carrier enabled
//   period, mode   active period/mode used to compute the next count
//   period_next    period in force once the next count is shown (post-load)
//   count          registered carrier value
//   count_next     combinational next carrier value
//   zero_evt       registered: shown count is 0 while running
//   peak_evt       registered: shown count equals its period while running
module pwm_carrier_compare_carrier_counter
   import pwm_carrier_compare_pkg::*;
#(
   parameter int CNT_WIDTH = CARCOUNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [CNT_WIDTH-1:0] period,
   input  _car_mode             mode,
   input  logic [CNT_WIDTH-1:0] period_next,
   output logic [CNT_WIDTH-1:0] count,
   output logic [CNT_WIDTH-1:0] count_next,
   output logic                 zero_evt,
   output logic                 peak_evt
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   _car_dir dir;
   _car_dir dir_next;
   logic    run_q;

   always_comb begin
      count_next = count;
      dir_next   = dir;
      // A stopped or just-started carrier holds at 0 so the first running cycle is a zero point;
      // a count above the period (period shrunk while stopped) also restarts from 0.
      if (!run || !run_q || (count > period)) begin
         count_next = '0;
         dir_next   = DIR_UP;
      end else if (mode == CAR_SAW) begin
         dir_next   = DIR_UP;
         count_next = (count == period) ? '0 : count + ONE;
      end else if (dir == DIR_UP) begin
         if (count != period) begin
            count_next = count + ONE;
         end else if (period <= ONE) begin
            count_next = '0;
            dir_next   = DIR_UP;
         end else begin
            count_next = count - ONE;
            dir_next   = DIR_DOWN;
         end
      end else begin
         if (count <= ONE) begin
            count_next = '0;
            dir_next   = DIR_UP;
         end else begin
            count_next = count - ONE;
            dir_next   = DIR_DOWN;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir      <= DIR_UP;
         run_q    <= 1'b0;
         count    <= '0;
         zero_evt <= 1'b0;
         peak_evt <= 1'b0;
      end else begin
         dir      <= dir_next;
         run_q    <= run;
         count    <= count_next;
         zero_evt <= run && (count_next == '0);
         peak_evt <= run && (count_next == period_next);
      end
   end

endmodule

// File: rtl/pwm_carrier_compare.sv
// rtl/pwm_carrier_compare.sv - carrier generator and duty comparator feeding dead_time
// Purpose: double-buffered period/compare/mode, shadow-to-active transfer at carrier zero,
//          registered comparator pwm = carrier < compare.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   cfg_period/compare/mode, cfg_wr  shadow write interface
//   pwm_onoff                        run enable
//   pwm, carrier                     comparator output and carrier value
//   zero_evt, peak_evt               carrier at 0 / at period (running only)
//   load_pending, load_done          shadow not yet transferred / transfer pulse
module pwm_carrier_compare
   import pwm_carrier_compare_pkg::*;
#(
   parameter int CNT_WIDTH = CARCOUNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CNT_WIDTH-1:0] cfg_period,
   input  logic [CNT_WIDTH-1:0] cfg_compare,
   input  _car_mode             cfg_mode,
   input  logic                 cfg_wr,
   input  _pwm_onoff            pwm_onoff,
   output logic                 pwm,
   output logic [CNT_WIDTH-1:0] carrier,
   output logic                 zero_evt,
   output logic                 peak_evt,
   output logic                 load_pending,
   output logic                 load_done
);

   logic [CNT_WIDTH-1:0] shadow_period, shadow_compare;
   logic [CNT_WIDTH-1:0] active_period, active_compare;
   logic [CNT_WIDTH-1:0] period_next, compare_next, count_next;
   _car_mode             shadow_mode, active_mode;
   logic                 run;
   logic                 transfer;

   assign run = (pwm_onoff == PWM_ON);

   // Transfer on the edge that makes the carrier 0, so a whole period (starting at its zero)
   // runs on one consistent set of values. While stopped the next count is always 0.
   assign transfer     = load_pending && (count_next == '0);
   assign period_next  = transfer ? shadow_period  : active_period;
   assign compare_next = transfer ? shadow_compare : active_compare;

   pwm_carrier_compare_carrier_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .period      (active_period),
      .mode        (active_mode),
      .period_next (period_next),
      .count       (carrier),
      .count_next  (count_next),
      .zero_evt    (zero_evt),
      .peak_evt    (peak_evt)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_period  <= '0;
         shadow_compare <= '0;
         shadow_mode    <= CAR_SAW;
         active_period  <= '0;
         active_compare <= '0;
         active_mode    <= CAR_SAW;
         load_pending   <= 1'b0;
         load_done      <= 1'b0;
         pwm            <= 1'b0;
      end else begin
         if (cfg_wr) begin
            shadow_period  <= cfg_period;
            shadow_compare <= cfg_compare;
            shadow_mode    <= cfg_mode;
         end
         if (transfer) begin
            active_period  <= shadow_period;
            active_compare <= shadow_compare;
            active_mode    <= shadow_mode;
         end
         // A write in the transfer cycle lands after the old shadow moved, so it stays pending.
         load_pending <= cfg_wr || (load_pending && !transfer);
         load_done    <= transfer;
         pwm          <= run && (count_next < compare_next);
      end
   end

endmodule
